// File: rtl/mem_io_bus_ctrl.sv
// mem_io_bus_ctrl: 8088 minimum-mode bus-cycle sequencer with window decode,
// one-hot chip selects, datapath strobes and per-class wait-state READY.
module mem_io_bus_ctrl #(
   parameter logic [19:0] MEM0_LSB = 20'h00000,
   parameter logic [19:0] MEM0_MSB = 20'h7FFFF,
   parameter logic [19:0] MEM1_LSB = 20'h80000,
   parameter logic [19:0] MEM1_MSB = 20'hFFFFF,
   parameter logic [15:0] IO0_LSB  = 16'hFF00,
   parameter logic [15:0] IO0_MSB  = 16'hFF0F,
   parameter logic [15:0] IO1_LSB  = 16'h1C00,
   parameter logic [15:0] IO1_MSB  = 16'h1DFF,
   parameter logic [3:0]  MEM_WAIT = 4'd0,
   parameter logic [3:0]  IO_WAIT  = 4'd2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ALE,
   input  logic        IOM,
   input  logic        RD,
   input  logic        WR,
   input  logic [19:0] Address,
   output logic [3:0]  cs,
   output logic        OE,
   output logic        rw,
   output logic        ld_Addr,
   output logic        ld_data,
   output logic        READY,
   output logic        bus_err
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] DECODE  = 3'd1;
   localparam logic [2:0] STROBE  = 3'd2;
   localparam logic [2:0] WAIT    = 3'd3;
   localparam logic [2:0] XFER    = 3'd4;
   localparam logic [2:0] RECOVER = 3'd5;
   logic [2:0]  state_q, state_d;
   logic [19:0] addr_q, addr_d;
   logic        iom_q, iom_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  cs_q, cs_d;
   logic        oe_q, oe_d, rw_q, rw_d, ld_addr_q, ld_addr_d, ld_data_q, ld_data_d;
   logic        ready_q, ready_d, bus_err_q, bus_err_d;
   logic [19:0] m0, m1;
   logic [15:0] i0, i1;
   logic [3:0]  hit, sel, wait_n;
   // Offset-from-base compares avoid constant-true bound checks on full-range windows
   assign m0  = addr_q - MEM0_LSB;
   assign m1  = addr_q - MEM1_LSB;
   assign i0  = addr_q[15:0] - IO0_LSB;
   assign i1  = addr_q[15:0] - IO1_LSB;
   assign hit = {iom_q && i1 <= IO1_MSB - IO1_LSB, iom_q && i0 <= IO0_MSB - IO0_LSB,
                 !iom_q && m1 <= MEM1_MSB - MEM1_LSB, !iom_q && m0 <= MEM0_MSB - MEM0_LSB};
   assign sel = hit[0] ? 4'b0001 : hit[1] ? 4'b0010 : hit[2] ? 4'b0100 : hit[3] ? 4'b1000 : 4'b0000;
   assign wait_n = ~|cs_q ? 4'd0 : iom_q ? IO_WAIT : MEM_WAIT;
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      iom_d     = iom_q;
      cnt_d     = cnt_q;
      cs_d      = cs_q;
      oe_d      = oe_q;
      rw_d      = rw_q;
      ld_addr_d = 1'b0;
      ld_data_d = 1'b0;
      ready_d   = ready_q;
      bus_err_d = 1'b0;
      case (state_q)
         IDLE: if (ALE) begin
            addr_d  = Address;
            iom_d   = IOM;
            state_d = DECODE;
         end
         DECODE: begin
            cs_d      = sel;
            ld_addr_d = |sel;
            bus_err_d = ~|sel;
            ready_d   = 1'b0;
            state_d   = STROBE;
         end
         STROBE: if (!RD && !WR) begin
            bus_err_d = 1'b1;
            cs_d      = 4'b0000;
            ready_d   = 1'b1;
            state_d   = RECOVER;
         end else if (!RD || !WR) begin
            rw_d    = !RD;
            cnt_d   = wait_n;
            state_d = wait_n == 4'd0 ? XFER : WAIT;
         end
         WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = cnt_q == 4'd1 ? XFER : WAIT;
         end
         XFER: begin
            ready_d   = 1'b1;
            oe_d      = |cs_q && rw_q;
            ld_data_d = |cs_q && !rw_q;
            state_d   = RECOVER;
         end
         RECOVER: begin
            oe_d = oe_q && !RD;
            if (RD && WR) begin
               cs_d    = 4'b0000;
               oe_d    = 1'b0;
               rw_d    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q   <= IDLE;
         addr_q    <= 20'h00000;
         iom_q     <= 1'b0;
         cnt_q     <= 4'd0;
         cs_q      <= 4'b0000;
         oe_q      <= 1'b0;
         rw_q      <= 1'b1;
         ld_addr_q <= 1'b0;
         ld_data_q <= 1'b0;
         ready_q   <= 1'b1;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         iom_q     <= iom_d;
         cnt_q     <= cnt_d;
         cs_q      <= cs_d;
         oe_q      <= oe_d;
         rw_q      <= rw_d;
         ld_addr_q <= ld_addr_d;
         ld_data_q <= ld_data_d;
         ready_q   <= ready_d;
         bus_err_q <= bus_err_d;
      end
   end
   assign cs      = cs_q;
   assign OE      = oe_q;
   assign rw      = rw_q;
   assign ld_Addr = ld_addr_q;
   assign ld_data = ld_data_q;
   assign READY   = ready_q;
   assign bus_err = bus_err_q;
endmodule

// File: tb/tb_mem_io_bus_ctrl.sv
// tb_mem_io_bus_ctrl: builds each bus cycle's expected output trace from the
// timing rules and checks the DUT against it every clock.
module tb_mem_io_bus_ctrl;
   localparam int MEM_W = 0;
   localparam int IO_W  = 2;
   localparam logic [9:0] IDLE_V = {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic        CLK, RESET, ALE, IOM, RD, WR;
   logic [19:0] Address;
   logic [3:0]  cs;
   logic        OE, rw, ld_Addr, ld_data, READY, bus_err;
   logic [9:0]  exp_q[$];
   int          n_chk = 0, n_fail = 0, cyc = 0;

   mem_io_bus_ctrl dut (
      .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR),
      .Address(Address), .cs(cs), .OE(OE), .rw(rw), .ld_Addr(ld_Addr),
      .ld_data(ld_data), .READY(READY), .bus_err(bus_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [3:0] model_cs(input logic [19:0] a, input logic io);
      logic [15:0] p;
      p = a[15:0];
      if (!io) return a < 20'h80000 ? 4'b0001 : 4'b0010;
      if (p >= 16'hFF00 && p <= 16'hFF0F) return 4'b0100;
      if (p >= 16'h1C00 && p <= 16'h1DFF) return 4'b1000;
      return 4'b0000;
   endfunction

   function automatic logic [9:0] vec(input logic [3:0] c, input logic oe, input logic rwv,
                                      input logic la, input logic ld, input logic rdy, input logic err);
      return {c, oe, rwv, la, ld, rdy, err};
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [19:0] ra();
      return 20'($urandom);
   endfunction

   task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %b, expected %b ({cs,OE,rw,ld_Addr,ld_data,READY,bus_err})",
                  nm, cyc, got, want);
      end
   endtask

   // One call per clock: inputs for the next edge and the outputs required after it
   task automatic step(input logic ale, input logic io, input logic rd, input logic wr,
                       input logic [19:0] a, input logic rst, input logic [9:0] e);
      @(negedge CLK);
      ALE = ale; IOM = io; RD = rd; WR = wr; Address = a; RESET = rst;
      exp_q.push_back(e);
   endtask

   task automatic idle_step();
      step(1'b0, rb(), 1'b1, 1'b1, ra(), 1'b1, IDLE_V);
   endtask

   // kind: 0 read, 1 write, 2 both strobes; d: cycles before strobe; h: extra strobe hold
   task automatic bus_cycle(input logic [19:0] a, input logic io, input int kind, input int d,
                            input int h, input logic am, input int rst_at, input int lit);
      logic [3:0] c;
      logic m, rdl, wrl, rwv;
      int n;
      c = model_cs(a, io);
      if (lit >= 0) begin
         chk("model_decode", {6'b0, c}, {6'b0, 4'(lit)});
         c = 4'(lit);
      end
      m   = |c;
      n   = !m ? 0 : io ? IO_W : MEM_W;
      rdl = kind == 1;
      wrl = kind == 0;
      rwv = kind != 1;
      step(1'b1, io, 1'b1, 1'b1, a, 1'b1, IDLE_V);
      step(1'b0, rb(), 1'b1, 1'b1, ra(), 1'b1, vec(c, 1'b0, 1'b1, m, 1'b0, 1'b0, !m));
      repeat (d) step(1'b0, rb(), 1'b1, 1'b1, ra(), 1'b1, vec(c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      if (kind == 2) begin
         step(1'b0, rb(), 1'b0, 1'b0, ra(), 1'b1, vec(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
         repeat (h) step(1'b0, rb(), 1'b0, 1'b0, ra(), 1'b1, vec(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
         idle_step();
         return;
      end
      step(1'b0, rb(), rdl, wrl, ra(), 1'b1, vec(c, 1'b0, rwv, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int i = 1; i <= n; i++) begin
         if (i == rst_at) begin
            step(1'b0, rb(), rdl, wrl, ra(), 1'b0, IDLE_V);
            idle_step();
            return;
         end
         step(am && i == 1, rb(), rdl, wrl, ra(), 1'b1, vec(c, 1'b0, rwv, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      step(1'b0, rb(), rdl, wrl, ra(), 1'b1, vec(c, m && rwv, rwv, 1'b0, m && !rwv, 1'b1, 1'b0));
      repeat (h) step(1'b0, rb(), rdl, wrl, ra(), 1'b1, vec(c, m && rwv, rwv, 1'b0, 1'b0, 1'b1, 1'b0));
      idle_step();
   endtask

   initial begin : compare
      logic [9:0] e;
      forever begin
         @(posedge CLK);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outputs", {cs, OE, rw, ld_Addr, ld_data, READY, bus_err}, e);
         end
      end
   end

   initial begin : stim
      RESET = 1'b0; ALE = 1'b0; IOM = 1'b0; RD = 1'b1; WR = 1'b1; Address = 20'h0;
      step(1'b0, 1'b0, 1'b1, 1'b1, 20'h0, 1'b0, IDLE_V);
      step(1'b0, 1'b0, 1'b1, 1'b1, 20'h0, 1'b0, IDLE_V);
      idle_step();
      bus_cycle(20'h00010, 1'b0, 0, 0, 1, 1'b0, -1, 1);
      bus_cycle(20'hA1234, 1'b0, 1, 1, 0, 1'b0, -1, 2);
      bus_cycle(20'h01C80, 1'b1, 0, 0, 1, 1'b0, -1, 8);
      bus_cycle(20'h02000, 1'b1, 1, 0, 0, 1'b0, -1, 0);
      bus_cycle(20'h0FF05, 1'b1, 2, 1, 1, 1'b0, -1, 4);
      bus_cycle(20'h01D00, 1'b1, 0, 0, 0, 1'b1, -1, 8);
      bus_cycle(20'h0FF00, 1'b1, 0, 0, 0, 1'b0, 1, 4);
      bus_cycle(20'h7FFFF, 1'b0, 0, 0, 0, 1'b0, -1, 1);
      bus_cycle(20'h80000, 1'b0, 1, 0, 2, 1'b0, -1, 2);
      bus_cycle(20'h3FF0F, 1'b1, 1, 2, 0, 1'b0, -1, 4);
      bus_cycle(20'h0FF10, 1'b1, 0, 0, 0, 1'b0, -1, 0);
      bus_cycle(20'h01BFF, 1'b1, 0, 0, 0, 1'b0, -1, 0);
      bus_cycle(20'h51DFF, 1'b1, 1, 0, 1, 1'b0, -1, 8);
      bus_cycle(20'h01C80, 1'b0, 0, 0, 0, 1'b0, -1, 1);
      for (int k = 0; k < 120; k++) begin
         logic [19:0] a;
         logic io, am;
         int sel, kind, rst_at;
         io  = rb();
         sel = $urandom_range(0, 3);
         a   = ra();
         if (io && sel == 0) a[15:0] = 16'hFF00 + 16'($urandom_range(0, 15));
         if (io && sel == 1) a[15:0] = 16'h1C00 + 16'($urandom_range(0, 511));
         kind   = $urandom_range(0, 9) == 0 ? 2 : $urandom_range(0, 1);
         am     = $urandom_range(0, 3) == 0;
         rst_at = $urandom_range(0, 7) == 0 ? $urandom_range(1, 2) : -1;
         bus_cycle(a, io, kind, $urandom_range(0, 2), $urandom_range(0, 2), am, rst_at, -1);
         repeat ($urandom_range(0, 2)) idle_step();
      end
      repeat (3) @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_io_bus_ctrl.md
# mem_io_bus_ctrl

Bus-cycle controller that sequences the shared memory/IO datapath banks on the 8088 minimum-mode bus. It samples ALE, IOM and the latched 20-bit address, decodes one of four devices (two memory banks, two IO ports), and drives the per-device chip selects and the datapath strobes OE, rw, ld_Addr and ld_data. It also drives the processor READY line to insert a programmable number of wait states per device class. Unmapped or malformed cycles complete without hanging the bus and are flagged.

## Interface
- MEM0_LSB, 20'h00000, memory bank 0 low bound (inclusive)
- MEM0_MSB, 20'h7FFFF, memory bank 0 high bound (inclusive)
- MEM1_LSB, 20'h80000, memory bank 1 low bound
- MEM1_MSB, 20'hFFFFF, memory bank 1 high bound
- IO0_LSB / IO0_MSB, 16'hFF00 / 16'hFF0F, IO port 0 window
- IO1_LSB / IO1_MSB, 16'h1C00 / 16'h1DFF, IO port 1 window
- MEM_WAIT, 4'd0, wait states inserted on memory cycles (0–15)
- IO_WAIT, 4'd2, wait states inserted on IO cycles (0–15)

- CLK  in  1  bus clock; all logic on posedge
- RESET  in  1  synchronous, active-low reset
- ALE  in  1  address latch enable from CPU
- IOM  in  1  1 = IO cycle, 0 = memory cycle
- RD  in  1  active-low read strobe
- WR  in  1  active-low write strobe
- Address  in  20  latched bus address (8282 latch output)
- cs  out  4  one-hot chip select: [0] MEM0, [1] MEM1, [2] IO0, [3] IO1
- OE  out  1  datapath output enable (read data onto bus)
- rw  out  1  1 = read, 0 = write
- ld_Addr  out  1  one-cycle pulse: datapath loads Address
- ld_data  out  1  one-cycle pulse: datapath captures write data
- READY  out  1  to CPU; 0 = insert wait state
- bus_err  out  1  one-cycle pulse on unmapped or malformed cycle

## Operation
- States: IDLE, DECODE, STROBE, WAIT, XFER, RECOVER.
- IDLE: on ALE=1 at the clock edge, register Address and IOM and go to DECODE. ALE in any other state is ignored.
- DECODE (1 cycle):
  - Memory cycles compare all 20 bits. IO cycles compare Address[15:0] only.
  - Exactly one window hit: cs gets that bit registered, ld_Addr=1 for this cycle, READY=0.
  - No hit: cs=0, bus_err pulses, and the cycle still runs with zero waits and no strobes.
  - Windows overlapping is a parameter error. Priority order is MEM0>MEM1>IO0>IO1.
- STROBE: hold until RD=0 or WR=0.
  - RD=0: rw=1.
  - WR=0: rw=0.
  - Both 0 on the same edge: bus_err pulse, cs cleared, go to RECOVER.
  - Wait count loads from MEM_WAIT or IO_WAIT by the registered IOM. If the count is 0, go to XFER; otherwise go to WAIT.
  - READY stays 0.
- WAIT: 4-bit down-counter decrements each cycle with READY=0. Leave for XFER in the cycle the count reaches 1, so exactly N cycles are spent in WAIT.
- XFER (1 cycle): READY=1.
  - Read: OE=1.
  - Write: ld_data=1.
  - Suppressed if cs=0 (unmapped).
  - Go to RECOVER.
- RECOVER:
  - Read: OE stays 1 while RD=0.
  - When RD=1 and WR=1, cs clears, OE=0, rw=1, go to IDLE.
- Reset (RESET=0 at an edge, any state) forces the following on that edge, aborting any cycle in progress:
  - state=IDLE, cs=0, OE=0, rw=1, ld_Addr=0, ld_data=0, READY=1, bus_err=0, counter=0.

## Timing
- All outputs are registered; no combinational input→output path.
- ALE sampled high at edge E:
  - ld_Addr and cs valid after E+1.
  - READY low after E+1, through the last WAIT cycle.
- Strobe seen at edge S: READY returns 1 after edge S+N+1 (N = wait count). OE/ld_data assert in the same cycle.
- ld_Addr, ld_data and bus_err are exactly one cycle wide.
- Minimum cycle is IDLE→DECODE→STROBE→XFER→RECOVER→IDLE, 5 edges with N=0 and the strobe already low.
- A new ALE is accepted only from IDLE. Back-to-back bus cycles are separated by at least one IDLE cycle.

## Test plan
- Memory read at 20'h00010, IOM=0, RD low → cs=4'b0001, ld_Addr 1 cycle, no READY wait after the strobe, OE=1 in XFER until RD high, then cs=0.
- Memory write at 20'hA1234 → cs=4'b0010, rw=0, ld_data single pulse in XFER, READY never low after the strobe.
- IO read at 16'h1C80 (IO_WAIT=2), IOM=1 → cs=4'b1000, READY low for exactly 2 cycles after the strobe edge, then OE=1.
- IO write at 16'h2000 (unmapped) → cs=0, bus_err one pulse in DECODE, no ld_data, READY released, FSM back in IDLE.
- RD and WR both low in STROBE → bus_err pulse, no OE/ld_data, return to IDLE once both are high. Separately, a second ALE during WAIT is ignored.
- RESET=0 asserted mid-WAIT on an IO cycle → next edge: READY=1, cs=0, OE=0, rw=1. The following memory read completes normally.
